stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_if.sv | 27 ++
 rtl/stage_sequencer.sv | 113 +++++++++++
 tb/tb_stage_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Signal bundle between the stage sequencer and its instruction/data-memory environment.
// mem_req (with mem_we) stays high every MEMORY cycle of a LOAD/STORE until mem_ready is sampled high on a rising edge.
interface stage_sequencer_if;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic [6:0]  target;
    logic        mem_ready;
    logic [6:0]  PC;
    logic [2:0]  state;
    logic        ir_we;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic        halted;
    logic [15:0] retired;

    modport master (
        output run, opcode, branch_taken, target, mem_ready,
        input  PC, state, ir_we, mem_req, mem_we, reg_we, halted, retired
    );

    modport slave (
        input  run, opcode, branch_taken, target, mem_ready,
        output PC, state, ir_we, mem_req, mem_we, reg_we, halted, retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with PC, retire counter and ECALL halt.
module stage_sequencer (
    input logic              clock,
    input logic              Reset,
    stage_sequencer_if.slave bus
);
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    logic [2:0]  state_q, state_d;
    logic [6:0]  pc_q, target_q;
    logic [15:0] retired_q;
    logic        cls_load, cls_store, cls_branch, cls_jal, cls_ecall, cls_writer;
    logic        redirect_q;
    logic        mem_class;
    logic        op_writer;

    assign mem_class = cls_load | cls_store;
    assign op_writer = (bus.opcode == 7'b0110011) || (bus.opcode == 7'b0010011) ||
                       (bus.opcode == 7'b0110111) || (bus.opcode == 7'b0010111) ||
                       (bus.opcode == OP_LOAD)    || (bus.opcode == OP_JAL);

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // A started memory access finishes on mem_ready regardless of run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (bus.run) state_d = S_DECODE;
            S_DECODE:    if (bus.run) state_d = S_EXECUTE;
            S_EXECUTE:   if (bus.run) state_d = S_MEMORY;
            S_MEMORY: begin
                if (mem_class) begin
                    if (bus.mem_ready) state_d = S_WRITEBACK;
                end else if (bus.run) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: if (bus.run) state_d = cls_ecall ? S_HALT : S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            pc_q       <= 7'd0;
            retired_q  <= 16'd0;
            target_q   <= 7'd0;
            redirect_q <= 1'b0;
            cls_load   <= 1'b0;
            cls_store  <= 1'b0;
            cls_branch <= 1'b0;
            cls_jal    <= 1'b0;
            cls_ecall  <= 1'b0;
            cls_writer <= 1'b0;
        end else if (bus.run) begin
            if (state_q == S_DECODE) begin
                cls_load   <= (bus.opcode == OP_LOAD);
                cls_store  <= (bus.opcode == OP_STORE);
                cls_branch <= (bus.opcode == OP_BRANCH);
                cls_jal    <= (bus.opcode == OP_JAL);
                cls_ecall  <= (bus.opcode == OP_ECALL);
                cls_writer <= op_writer;
            end
            if (state_q == S_EXECUTE) begin
                redirect_q <= cls_jal | (cls_branch & bus.branch_taken);
                if (cls_jal | (cls_branch & bus.branch_taken)) target_q <= bus.target;
            end
            if (state_q == S_WRITEBACK) begin
                retired_q <= retired_q + 16'd1;
                if (!cls_ecall) pc_q <= redirect_q ? target_q : pc_q + 7'd1;
            end
        end
    end

    always_comb begin
        bus.ir_we   = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.reg_we  = 1'b0;
        bus.halted  = 1'b0;
        if (Reset) begin
            case (state_q)
                S_FETCH:     bus.ir_we  = bus.run;
                S_MEMORY: begin
                    bus.mem_req = mem_class;
                    bus.mem_we  = cls_store;
                end
                S_WRITEBACK: bus.reg_we = bus.run & cls_writer;
                S_HALT:      bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.PC      = pc_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: instruction-level reference model feeds a retirement scoreboard.
module tb_stage_sequencer;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_ADD    = 7'b0110011;

    typedef struct packed {
        logic [6:0]  pc;
        logic [15:0] retired;
        logic        halted;
        logic [7:0]  cycles;
        logic [7:0]  n_ir;
        logic [7:0]  n_req;
        logic [7:0]  n_we;
        logic [7:0]  n_reg;
    } exp_t;

    logic clock = 1'b0;
    logic Reset;
    stage_sequencer_if bus();

    stage_sequencer dut (.clock(clock), .Reset(Reset), .bus(bus));

    always #5 clock = ~clock;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  m_pc;
    logic [15:0] m_retired;
    logic        m_halted;
    bit          mon_en = 1'b0;
    int          mon_cyc, mon_ir, mon_req, mon_we, mon_reg;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.run = 1'b0;
        repeat (n) tick();
    endtask

    function automatic bit is_writer(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, OP_LOAD, OP_JAL};
    endfunction

    task automatic model_reset();
        m_pc = 7'd0;
        m_retired = 16'd0;
        m_halted = 1'b0;
    endtask

    // One instruction: predict its retirement, then drive its cycle-by-cycle schedule.
    task automatic do_instr(input logic [6:0] op, input logic taken, input logic [6:0] tgt,
                            input int waits, input int st_stage, input int st_len);
        exp_t e;
        bit   mem_op;
        int   w;
        mem_op = (op == OP_LOAD) || (op == OP_STORE);
        w = mem_op ? waits : 0;
        e.cycles = 8'(5 + w + st_len);
        e.n_ir   = 8'd1;
        e.n_req  = mem_op ? 8'(w + 1) : 8'd0;
        e.n_we   = (op == OP_STORE) ? 8'(w + 1) : 8'd0;
        e.n_reg  = is_writer(op) ? 8'd1 : 8'd0;
        if (op == OP_ECALL) m_halted = 1'b1;
        else if (op == OP_JAL || (op == OP_BRANCH && taken)) m_pc = tgt;
        else m_pc = m_pc + 7'd1;
        m_retired = m_retired + 16'd1;
        e.pc = m_pc;
        e.retired = m_retired;
        e.halted = m_halted;
        exp_q.push_back(e);

        bus.opcode = op;
        bus.branch_taken = taken;
        bus.target = tgt;
        for (int s = 0; s < 5; s++) begin
            if (s == st_stage) begin
                for (int k = 0; k < st_len; k++) begin
                    bus.run = 1'b0;
                    bus.mem_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            if (s == 3 && mem_op) begin
                for (int k = 0; k < w; k++) begin
                    bus.run = 1'($urandom_range(0, 1));
                    bus.mem_ready = 1'b0;
                    tick();
                end
                bus.run = 1'($urandom_range(0, 1));
                bus.mem_ready = 1'b1;
                tick();
            end else begin
                bus.run = 1'b1;
                bus.mem_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
    endtask

    // Monitor: each change of retired closes one instruction and is scored against the queue head.
    initial begin
        logic [15:0] prev;
        exp_t        e;
        prev = 16'd0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                prev = 16'd0;
                mon_cyc = 0; mon_ir = 0; mon_req = 0; mon_we = 0; mon_reg = 0;
            end else begin
                if (bus.retired !== prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 32'(bus.retired), 32'(prev));
                    end else begin
                        e = exp_q.pop_front();
                        check("retire_pc", 32'(bus.PC), 32'(e.pc));
                        check("retire_count", 32'(bus.retired), 32'(e.retired));
                        check("retire_halted", 32'(bus.halted), 32'(e.halted));
                        check("retire_state", 32'(bus.state), e.halted ? 32'd5 : 32'd0);
                        check("latency", 32'(mon_cyc), 32'(e.cycles));
                        check("ir_we_pulses", 32'(mon_ir), 32'(e.n_ir));
                        check("mem_req_cycles", 32'(mon_req), 32'(e.n_req));
                        check("mem_we_cycles", 32'(mon_we), 32'(e.n_we));
                        check("reg_we_pulses", 32'(mon_reg), 32'(e.n_reg));
                    end
                    prev = bus.retired;
                    mon_cyc = 0; mon_ir = 0; mon_req = 0; mon_we = 0; mon_reg = 0;
                end
                mon_cyc++;
                mon_ir  += int'(bus.ir_we);
                mon_req += int'(bus.mem_req);
                mon_we  += int'(bus.mem_we);
                mon_reg += int'(bus.reg_we);
            end
        end
    end

    initial begin
        logic [6:0] op;
        int         sel, waits, st_stage, st_len;
        bit         mem_op;

        Reset = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 7'd0;
        bus.branch_taken = 1'b0;
        bus.target = 7'd0;
        bus.mem_ready = 1'b0;
        model_reset();
        #1 Reset = 1'b0;
        #2;
        check("rst_pc", 32'(bus.PC), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        bus.run = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("rst_ir_we", 32'(bus.ir_we), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_reg_we", 32'(bus.reg_we), 32'd0);
        tick();
        tick();
        Reset = 1'b1;
        mon_en = 1'b1;

        // Directed: ADD stream, LOAD with waits, branches, stalls, wrap, ECALL halt.
        repeat (3) do_instr(OP_ADD, 1'b0, 7'd5, 0, -1, 0);
        do_instr(OP_LOAD, 1'b1, 7'd20, 3, -1, 0);
        do_instr(7'b0000000, 1'b1, 7'd33, 0, -1, 0);
        do_instr(OP_BRANCH, 1'b1, 7'h40, 0, -1, 0);
        do_instr(OP_BRANCH, 1'b0, 7'h11, 0, -1, 0);
        do_instr(OP_ADD, 1'b0, 7'd0, 0, 2, 4);
        do_instr(OP_STORE, 1'b1, 7'd3, 2, 4, 2);
        do_instr(OP_JAL, 1'b0, 7'd127, 0, -1, 0);
        do_instr(7'b1111111, 1'b1, 7'd50, 0, -1, 0);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2: op = OP_BRANCH;
                3: op = OP_JAL;
                4: op = OP_ADD;
                5: op = 7'b0010011;
                6: op = 7'b0110111;
                7: op = 7'b0010111;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    if (op == OP_ECALL) op = 7'b0001111;
                end
            endcase
            mem_op = (op == OP_LOAD) || (op == OP_STORE);
            waits = $urandom_range(0, 4);
            st_stage = -1;
            st_len = 0;
            if ($urandom_range(0, 3) == 0) begin
                st_stage = $urandom_range(0, 4);
                if (mem_op && st_stage == 3) st_stage = 4;
                st_len = $urandom_range(1, 3);
            end
            do_instr(op, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), waits, st_stage, st_len);
        end

        do_instr(OP_JAL, 1'b0, 7'd9, 0, -1, 0);
        do_instr(OP_ECALL, 1'b1, 7'd70, 0, -1, 0);
        for (int i = 0; i < 20; i++) begin
            bus.run = 1'b1;
            bus.opcode = 7'($urandom_range(0, 127));
            bus.mem_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("halt_queue_drained", 32'(exp_q.size()), 32'd0);
        check("halt_pc", 32'(bus.PC), 32'(m_pc));
        check("halt_state", 32'(bus.state), 32'd5);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_retired", 32'(bus.retired), 32'(m_retired));
        check("halt_strobes", 32'(mon_ir + mon_req + mon_we + mon_reg), 32'd0);

        // Reset exits HALT; then reset in the middle of a STORE access.
        mon_en = 1'b0;
        Reset = 1'b0;
        idle(2);
        Reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        repeat (2) do_instr(OP_ADD, 1'b0, 7'd0, 0, -1, 0);
        bus.opcode = OP_STORE;
        bus.run = 1'b1;
        bus.mem_ready = 1'b0;
        repeat (4) tick();
        check("store_mem_req", 32'(bus.mem_req), 32'd1);
        check("store_mem_we", 32'(bus.mem_we), 32'd1);
        check("store_state", 32'(bus.state), 32'd3);
        #2;
        mon_en = 1'b0;
        Reset = 1'b0;
        #1;
        check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("midrst_pc", 32'(bus.PC), 32'd0);
        check("midrst_retired", 32'(bus.retired), 32'd0);
        check("midrst_state", 32'(bus.state), 32'd0);
        exp_q.delete();
        idle(2);
        check("midrst_no_writeback", 32'(bus.retired), 32'd0);
        Reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        repeat (2) do_instr(OP_ADD, 1'b1, 7'd90, 0, -1, 0);
        idle(3);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
